// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter: round-robin, packet-locked arbiter for one mesh-router
// output port. The winner keeps the grant until its tail flit transfers or
// until it has stalled for TIMEOUT cycles. Every release spends one cycle idle.
module rr_packet_arbiter #(
  parameter  int N       = 5,
  parameter  int TIMEOUT = 16,
  parameter  int CW      = $clog2(TIMEOUT+1),
  localparam int IW      = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_tail,
  input  logic          i_out_ready,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_locked,
  output logic          o_xfer,
  output logic          o_timeout
);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t                r_state, w_state_nxt;
  logic [N-1:0]          r_grant, w_grant_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic [IW-1:0]         r_ptr, w_ptr_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  r_timeout, w_timeout_nxt;

  logic [N-1:0][IW-1:0]  w_rot;     // w_rot[k] = (ptr + k) mod N
  logic [N-1:0]          w_hit;     // request seen at rotated slot k
  logic                  w_win_vld;
  logic [IW-1:0]         w_win;
  logic                  w_g_req;
  logic                  w_g_tail;
  logic [IW-1:0]         w_ptr_inc;

  // Rotated search order: slot 0 is the current priority holder.
  for (genvar k = 0; k < N; k++) begin : g_rot
    assign w_rot[k] = (int'(r_ptr) + k >= N) ? IW'(int'(r_ptr) + k - N)
                                             : IW'(int'(r_ptr) + k);
    assign w_hit[k] = i_req[w_rot[k]];
  end

  // Pick the lowest rotated slot with a request; scanning high to low lets
  // the last hit written be the one closest to ptr.
  always_comb begin
    w_win_vld = 1'b0;
    w_win     = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_win_vld = 1'b1;
        w_win     = w_rot[k];
      end
    end
  end

  // Grant is one-hot, so masking selects the holder's req/tail without a mux.
  assign w_g_req   = |(r_grant & i_req);
  assign w_g_tail  = |(r_grant & i_tail);
  assign w_ptr_inc = (r_idx == IW'(N-1)) ? '0 : r_idx + 1'b1;

  // Next-state and next-output logic; a release always lands in IDLE.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_idx_nxt     = r_idx;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) begin
          w_state_nxt = S_LOCKED;
          w_grant_nxt = N'(1) << w_win;
          w_idx_nxt   = w_win;
          w_cnt_nxt   = '0;
        end
      end
      S_LOCKED: begin
        if (o_xfer) begin
          w_cnt_nxt = '0;
          if (w_g_tail) begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_idx_nxt   = '0;
            w_ptr_nxt   = w_ptr_inc;
          end
        end else if (r_cnt == CW'(TIMEOUT-1)) begin
          // Holder stalled too long: drop it and move priority past it.
          w_state_nxt   = S_IDLE;
          w_grant_nxt   = '0;
          w_idx_nxt     = '0;
          w_ptr_nxt     = w_ptr_inc;
          w_cnt_nxt     = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_idx     <= w_idx_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign o_grant     = r_grant;
  assign o_grant_idx = r_idx;
  assign o_locked    = (r_state == S_LOCKED);
  assign o_xfer      = w_g_req & i_out_ready;
  assign o_timeout   = r_timeout;

  a_onehot: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    $onehot0(r_grant));
  a_locked: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    o_locked == (r_grant != '0));
  a_tmo: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    r_timeout |-> $past(o_locked));

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Bench for rr_packet_arbiter: directed scenarios plus random traffic, all
// compared against a packet-level reference model of the arbitration rules.
module tb_rr_packet_arbiter;
  localparam int N  = 5;
  localparam int TO = 4;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req, tail;
  logic          rdy;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gidx;
  logic          lk, xf, tmo;

  rr_packet_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_tail(tail),
    .i_out_ready(rdy), .o_grant(gnt), .o_grant_idx(gidx), .o_locked(lk),
    .o_xfer(xf), .o_timeout(tmo)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int xf_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who holds the output, where priority starts, how long
  // the holder has been stalled, and whether a forced release just happened.
  bit m_lk;
  int m_g, m_ptr, m_st;
  bit m_to;

  function automatic void mreset();
    m_lk = 0; m_g = 0; m_ptr = 0; m_st = 0; m_to = 0;
  endfunction

  function automatic bit m_xfer();
    return m_lk && req[m_g] && rdy;
  endfunction

  function automatic void mdl();
    bit mv;
    if (!rst_n) begin mreset(); return; end
    mv   = m_xfer();
    m_to = 0;
    if (!m_lk) begin
      for (int k = 0; k < N; k++) begin
        if (req[(m_ptr + k) % N]) begin
          m_lk = 1; m_g = (m_ptr + k) % N; m_st = 0;
          break;
        end
      end
    end else if (mv) begin
      m_st = 0;
      if (tail[m_g]) begin m_lk = 0; m_ptr = (m_g + 1) % N; end
    end else begin
      m_st++;
      if (m_st == TO) begin
        m_lk = 0; m_ptr = (m_g + 1) % N; m_st = 0; m_to = 1;
      end
    end
  endfunction

  // Called at posedge+1 with inputs already set: check mid-cycle, then
  // advance the model across the edge.
  task automatic step();
    #4;
    chk("grant",  gnt,  m_lk ? (32'd1 << m_g) : 32'd0);
    chk("gidx",   gidx, m_lk ? m_g : 0);
    chk("locked", lk,   m_lk);
    chk("xfer",   xf,   m_xfer());
    chk("tmo",    tmo,  m_to);
    xf_cnt += int'(xf);
    @(posedge clk);
    mdl();
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 0; req = '0; tail = '0; rdy = 0;
    mreset();
    step();
    rst_n = 1;
  endtask

  initial begin
    int fc[N];
    int seq[$];
    int lk_cnt;
    bit prev_lk;
    mreset();
    rst_n = 0; req = '0; tail = '0; rdy = 0;
    @(posedge clk); #1;

    // Reset held, then idle with no requests.
    repeat (3) step();
    rst_n = 1;
    repeat (10) step();

    // Single three-flit packet on port 2.
    req = 5'b00100; rdy = 1; tail = '0;
    step();
    chk("sp_grant", gnt, 5'b00100);
    xf_cnt = 0;
    step(); step();
    tail = 5'b00100;
    step();
    chk("sp_xfers", xf_cnt, 3);
    req = '0; tail = '0;
    chk("sp_rel", gnt, 0);
    req = 5'b00011; tail = 5'b00011;
    step();
    chk("sp_next", gnt, 5'b00001);
    step();
    req = '0; tail = '0;
    step();

    // Fairness: all ports requesting two-flit packets.
    rst_pulse();
    foreach (fc[i]) fc[i] = 0;
    req = '1; rdy = 1; lk_cnt = 0; prev_lk = 0;
    for (int c = 0; c < 18; c++) begin
      bit mv;
      int g;
      for (int i = 0; i < N; i++) tail[i] = fc[i][0];
      mv = m_xfer(); g = m_g;
      step();
      if (mv) fc[g]++;
      if (lk) lk_cnt++;
      if (lk && !prev_lk) seq.push_back(int'(gidx));
      prev_lk = lk;
    end
    chk("fair_n", seq.size(), 6);
    for (int i = 0; i < 6 && i < seq.size(); i++) chk("fair_seq", seq[i], i % N);
    chk("fair_lk", lk_cnt, 12);
    req = '0; tail = '0;
    step();

    // Pointer wrap: serve port 3, then 0, then 3 again.
    rst_pulse();
    req = 5'b01000; tail = 5'b01000; rdy = 1;
    step();
    chk("wrap_g3", gnt, 5'b01000);
    req = 5'b01001; tail = 5'b01001;
    step(); step();
    chk("wrap_g0", gnt, 5'b00001);
    step(); step();
    chk("wrap_g3b", gnt, 5'b01000);
    step();
    req = '0; tail = '0;
    step();

    // Backpressure until the watchdog fires.
    rst_pulse();
    req = 5'b00010; rdy = 0; tail = '0;
    step();
    for (int i = 0; i < TO; i++) begin
      chk("to_lk", lk, 1);
      step();
    end
    chk("to_pulse", tmo, 1);
    chk("to_gnt", gnt, 0);
    req = 5'b00011;
    step();
    chk("to_next", gnt, 5'b00001);
    chk("to_once", tmo, 0);
    rdy = 1; tail = 5'b00011;
    step();
    req = '0; tail = '0;
    step(); step();

    // Reset between edges in the middle of a packet.
    rst_pulse();
    req = 5'b00100; rdy = 1; tail = '0;
    step(); step();
    chk("mr_pre", lk, 1);
    #1 rst_n = 0;
    #1;
    chk("mr_gnt", gnt, 0);
    chk("mr_lk", lk, 0);
    mreset();
    step();
    rst_n = 1; req = 5'b00100;
    step();
    chk("mr_regnt", gnt, 5'b00100);
    tail = 5'b00100;
    step();
    req = '0; tail = '0;
    step();

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      req   = N'($urandom);
      tail  = '0;
      for (int i = 0; i < N; i++) tail[i] = ($urandom_range(0, 9) < 3);
      rdy   = ($urandom_range(0, 9) < 6);
      rst_n = ($urandom_range(0, 299) != 0);
      if (!rst_n) mreset();
      step();
    end
    rst_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/rr_packet_arbiter.md
Name: rr_packet_arbiter

Overview:
- Round-robin arbiter that shares one mesh-router output port between N input requesters.
- Replaces the fixed-priority chain of arbiter cells with fair, rotating priority.
- Holds the grant for a whole packet until its tail flit transfers.
- A watchdog releases a grant whose holder stalls.
- Sits between the input-port buffers and the output-port crossbar select.

Parameters:
- N, 5, number of requesters (router input ports); N ≥ 2.
- TIMEOUT, 16, stalled cycles allowed while locked before forced release; ≥ 1.
- CW, $clog2(TIMEOUT+1), width of the stall counter.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- req  input  N  req[i]=1: requester i has a flit for this output.
- tail  input  N  tail[i]=1: requester i's current flit is a packet tail.
- out_ready  input  1  downstream can accept a flit this cycle.
- grant  output  N  one-hot (or zero) registered grant; drives the crossbar select.
- grant_idx  output  $clog2(N)  binary index of the granted requester; 0 when idle.
- locked  output  1  1 while a grant is held (state LOCKED).
- xfer  output  1  combinational: |(grant & req) & out_ready. A flit moves this cycle.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async, reset_n=0):
  - grant=0, grant_idx=0, locked=0, timeout=0.
  - state=IDLE, priority pointer ptr=0, stall counter cnt=0.
- Arbitration (IDLE state):
  - If req≠0, the winner w is the first set bit searching from ptr upward, wrapping N-1→0.
  - Next edge: grant=onehot(w), grant_idx=w, state=LOCKED, cnt=0.
  - If req=0: remain IDLE, all outputs 0.
- Latency: request to grant is 1 cycle; the first transfer can occur in the cycle grant is visible.
- LOCKED state, each cycle with grant on requester g:
  - Transfer and tail[g]=1: next edge grant=0, locked=0, ptr=(g+1) mod N, state=IDLE.
  - Transfer and tail[g]=0: stay LOCKED, cnt=0.
  - No transfer: cnt increments. Causes are req[g]=0 (source bubble) or out_ready=0.
  - If cnt would reach TIMEOUT: next edge forced release as for tail, ptr=(g+1) mod N, timeout=1 for one cycle.
- Inter-packet gap: a release always returns to IDLE for exactly one cycle before the next grant. Back-to-back packets therefore see one bubble.
- grant changes only on clock edges and never changes while LOCKED except by release.
- Requests from other ports while LOCKED are ignored; they are not queued.
- req[g] deasserted while locked does not release the grant; only tail or timeout releases.
- Single-flit packet (tail set on first transfer): grant lasts exactly the cycles until that transfer.
- ptr advances only on release. It never advances in IDLE when req=0.
- Wrap-around: a winner at N-1 sets ptr=0.
- All requesters active continuously: grants cycle 0,1,…,N-1,0 in order.
- Reset asserted mid-packet clears the lock immediately (asynchronously). The packet is abandoned; upstream recovery is not this block's job.
- Assertions:
  - grant is one-hot or zero.
  - locked == (grant≠0).
  - timeout implies locked was 1 in the previous cycle.

Test Plan:
- Reset then idle: reset_n=0 for 3 cycles, req=0 → grant=0, locked=0, timeout=0 throughout. Release reset, hold req=0 for 10 cycles → all outputs 0 and ptr stays 0.
- Single packet (N=5): req=5'b00100, out_ready=1, tail on 3rd flit → grant=00100 one cycle after req. xfer high for 3 cycles, then grant=0. Next grant search starts at 3.
- Fairness: req=5'b11111 held, each packet 2 flits (tail on 2nd), out_ready=1 → grant sequence 0,1,2,3,4,0. Each grant lasts 2 cycles followed by one idle cycle.
- Wrap/pointer: ptr=4 (after serving port 3), req=5'b01001 → grant requester 0. Then req=5'b01001 again → grant requester 3.
- Backpressure and timeout (TIMEOUT=4): granted port 1, out_ready=0 → locked for 4 stalled cycles, timeout pulses once, grant=0. With req=5'b00011 still set, next grant goes to port 0 (ptr=2, wraps).
- Mid-packet reset: granted port 2 after 1 of 3 flits, assert reset_n=0 between edges → grant=0 and locked=0 immediately. After release with req=5'b00100 → grant port 2 from ptr=0.
